// File: rtl/clk_div_pkg.sv
// Shared definitions for the divided-clock monitor: FSM state encoding,
// default counter width and a helper for sizing the lock-run counter.
`timescale 1ns/1ps
package clk_div_pkg;

    // Default width of the period / high-time counters.
    localparam int CNT_W_DEF = 8;

    // Monitor FSM states.
    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_EDGE = 2'd1,
        MEASURE   = 2'd2,
        LOCKED    = 2'd3
    } mon_state_e;

    // Bits needed to count matching periods up to lock_cnt inclusive.
    function automatic int run_width(input int lock_cnt);
        int w;
        w = $clog2(lock_cnt + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop synchronizer for bringing asynchronous signals into clk.
// Each bit is synchronized independently; no relationship between bits of a
// multi-bit input is preserved.
`timescale 1ns/1ps
module sync_2ff #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_bit
            logic s1_q;
            logic s2_q;

            // Two-stage capture of one asynchronous bit.
            always_ff @(posedge clk or negedge rstn) begin
                if (!rstn) begin
                    s1_q <= 1'b0;
                    s2_q <= 1'b0;
                end else begin
                    s1_q <= d_i[gi];
                    s2_q <= s1_q;
                end
            end

            assign q_o[gi] = s2_q;
        end
    endgenerate

endmodule

// File: rtl/clk_div_mon.sv
// Divided-clock monitor. Samples clk_div_in in the source clk domain, measures
// the period and high time between successive rising edges, declares lock
// after LOCK_CNT consecutive periods of DIV_N, and raises a sticky err on a
// wrong period or a stopped clock (no rise within TIMEOUT cycles).
// Optional build macro CLK_DIV_MON_DUTY_CHK_EN: also require the measured high
// time to be DIV_N/2 or (DIV_N+1)/2, treating a violation as a bad period.
`timescale 1ns/1ps
module clk_div_mon
    import clk_div_pkg::*;
#(
    parameter int DIV_N    = 5,
    parameter int LOCK_CNT = 4,
    parameter int CNT_W    = CNT_W_DEF,
    parameter int TIMEOUT  = 2 * DIV_N
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             clk_div_in,
    input  logic             enable,
    output logic [CNT_W-1:0] period_cnt,
    output logic [CNT_W-1:0] high_cnt,
    output logic             period_vld,
    output logic             locked,
    output logic             err
);

    localparam int               RUN_W     = run_width(LOCK_CNT);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] DIV_N_C   = CNT_W'(DIV_N);
    localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);
    localparam logic [RUN_W-1:0] RUN_ONE   = RUN_W'(1);
    localparam logic [RUN_W-1:0] LOCK_C    = RUN_W'(LOCK_CNT);

    mon_state_e       state_q, state_d;
    logic             s2;
    logic             s3_q;
    logic             rise;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] hcnt_q, hcnt_d;
    logic [RUN_W-1:0] run_q, run_d;
    logic [CNT_W-1:0] period_cnt_q, period_cnt_d;
    logic [CNT_W-1:0] high_cnt_q, high_cnt_d;
    logic             period_vld_q, period_vld_d;
    logic             err_q, err_d;
    logic             duty_bad;
    logic             meas_bad;
    logic             timeout_hit;

    // Bring the divided clock into the clk domain (s1, s2).
    sync_2ff #(
        .WIDTH (1)
    ) u_sync (
        .clk  (clk),
        .rstn (rstn),
        .d_i  (clk_div_in),
        .q_o  (s2)
    );

    // History flop (s3) for edge detection on the synchronized level.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            s3_q <= 1'b0;
        end else begin
            s3_q <= s2;
        end
    end

    // The fixed synchronizer latency delays every edge equally, so periods
    // measured between rises are exact. A fall needs no explicit decode: the
    // high counter simply stops advancing once s2 is low.
    assign rise = s2 & ~s3_q;

`ifdef CLK_DIV_MON_DUTY_CHK_EN
    localparam logic [CNT_W-1:0] HIGH_LO = CNT_W'(DIV_N / 2);
    localparam logic [CNT_W-1:0] HIGH_HI = CNT_W'((DIV_N + 1) / 2);
    // Odd dividers may produce either half of the period as the high time.
    assign duty_bad = (hcnt_q != HIGH_LO) && (hcnt_q != HIGH_HI);
`else
    assign duty_bad = 1'b0;
`endif

    assign meas_bad    = (cnt_q != DIV_N_C) || duty_bad;
    assign timeout_hit = (cnt_q >= TIMEOUT_C);

    // FSM state register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Counters, measurement registers and status flags.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt_q        <= '0;
            hcnt_q       <= '0;
            run_q        <= '0;
            period_cnt_q <= '0;
            high_cnt_q   <= '0;
            period_vld_q <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            hcnt_q       <= hcnt_d;
            run_q        <= run_d;
            period_cnt_q <= period_cnt_d;
            high_cnt_q   <= high_cnt_d;
            period_vld_q <= period_vld_d;
            err_q        <= err_d;
        end
    end

    // Next-state and measurement logic; enable low overrides everything.
    always_comb begin
        state_d      = state_q;
        cnt_d        = rise ? CNT_ONE
                            : ((cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_ONE);
        hcnt_d       = rise ? CNT_ONE
                            : ((s2 && (hcnt_q != CNT_MAX)) ? hcnt_q + CNT_ONE : hcnt_q);
        run_d        = run_q;
        period_cnt_d = period_cnt_q;
        high_cnt_d   = high_cnt_q;
        period_vld_d = 1'b0;
        err_d        = err_q;

        if (!enable) begin
            state_d      = IDLE;
            cnt_d        = '0;
            hcnt_d       = '0;
            run_d        = '0;
            period_cnt_d = '0;
            high_cnt_d   = '0;
            err_d        = 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    cnt_d   = '0;
                    hcnt_d  = '0;
                    run_d   = '0;
                    err_d   = 1'b0;
                    state_d = WAIT_EDGE;
                end
                WAIT_EDGE: begin
                    // The first rise only marks a period start; the partial
                    // period before it is never reported.
                    if (rise) begin
                        state_d = MEASURE;
                    end
                end
                MEASURE, LOCKED: begin
                    if (rise) begin
                        period_cnt_d = cnt_q;
                        high_cnt_d   = hcnt_q;
                        period_vld_d = 1'b1;
                        if (meas_bad) begin
                            run_d   = '0;
                            err_d   = 1'b1;
                            state_d = MEASURE;
                        end else if (state_q == MEASURE) begin
                            run_d = run_q + RUN_ONE;
                            if (run_d == LOCK_C) begin
                                state_d = LOCKED;
                            end
                        end
                    end else if (timeout_hit) begin
                        run_d   = '0;
                        err_d   = 1'b1;
                        state_d = WAIT_EDGE;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    assign period_cnt = period_cnt_q;
    assign high_cnt   = high_cnt_q;
    assign period_vld = period_vld_q;
    assign locked     = (state_q == LOCKED);
    assign err        = err_q;

endmodule

// File: doc/clk_div_mon.md
Name: clk_div_mon

Overview:
- Downstream checker for the odd/even clock dividers. Samples a divided clock (clk_div_in) in the source clk domain and measures its period in clk cycles.
- Declares lock after a run of correct periods; flags wrong-period or stopped clocks.
- Sits between a divider output and the clock-status/interrupt logic; is itself clocked by the divider's source clk.

Parameters:
- DIV_N, 5, expected divide ratio (period in clk cycles), 2..2^CNT_W-2
- LOCK_CNT, 4, consecutive matching periods required to assert locked, >=1
- CNT_W, 8, width of period/high counters
- TIMEOUT, 2*DIV_N, clk cycles without a rising edge before declaring the divided clock stopped; must be < 2^CNT_W

Ports:
- clk  input  1  source clock (the clock feeding the divider)
- rstn  input  1  asynchronous active-low reset
- clk_div_in  input  1  divided clock under test (treated as asynchronous data)
- enable  input  1  monitor enable; low = all state cleared synchronously
- period_cnt  output  CNT_W  last measured period, clk cycles
- high_cnt  output  CNT_W  last measured high time, clk posedge samples
- period_vld  output  1  one-cycle pulse when period_cnt/high_cnt update
- locked  output  1  divided clock verified at DIV_N
- err  output  1  sticky error; cleared only by enable low or reset

Behaviour:
- Reset: rstn is asynchronous, active-low. While low, all flops are 0, state is IDLE, and every output is 0.
- Input path:
  - 2-flop synchronizer (s1, s2) followed by one history flop s3.
  - rise = s2 & ~s3; fall = ~s2 & s3.
  - Latency from a clk_div_in edge to rise/fall is 2-3 clk cycles. This latency is constant, so periods are unaffected.
- Counters:
  - cnt is loaded with 1 on rise, otherwise increments, saturating at 2^CNT_W-1.
  - hcnt is loaded with 1 on rise, increments while s2=1, and holds on fall.
- FSM states:
  - IDLE: enable=0. cnt, hcnt and match run cleared; locked=0; err=0. Goes to WAIT_EDGE when enable=1.
  - WAIT_EDGE: counters run, no measurement. First rise goes to MEASURE, since the first partial period is discarded.
  - MEASURE: on each rise, period_cnt<=cnt, high_cnt<=hcnt, period_vld=1 for that cycle.
    - If cnt==DIV_N, run++. When run reaches LOCK_CNT, go to LOCKED and set locked=1 in the same cycle.
    - If cnt!=DIV_N, run<=0 and err<=1; stay in MEASURE.
  - LOCKED: each rise updates the outputs as in MEASURE.
    - On mismatch: locked<=0, err<=1, run<=0, go to MEASURE.
- Timeout: in MEASURE or LOCKED, if cnt reaches TIMEOUT with no rise, then err<=1, locked<=0, run<=0, and the FSM goes to WAIT_EDGE. period_cnt holds its last value.
- Enable low in any state: next cycle goes to IDLE and clears everything, including err and the period/high registers. Re-enable always requires a fresh lock.
- Simultaneous events:
  - rise and TIMEOUT in the same cycle: rise wins and is measured normally.
  - enable low and rise in the same cycle: enable wins.
- period_vld never asserts in IDLE or WAIT_EDGE.

Optional Feature:
- Macro: CLK_DIV_MON_DUTY_CHK_EN.
- Defined: on each rise in MEASURE or LOCKED, high_cnt must be in {DIV_N/2, (DIV_N+1)/2} (integer division). This allows the half-cycle high time of a negedge-combined odd divider. A violation is treated exactly like a period mismatch (run<=0, err<=1, lock lost).
- Not defined: high_cnt is still reported but is never checked.

Decomposition:
- Package clk_div_pkg holds:
  - FSM state encoding: IDLE=2'd0, WAIT_EDGE=2'd1, MEASURE=2'd2, LOCKED=2'd3.
  - Default CNT_W.
- Sub-module sync_2ff (generic, WIDTH parameter, asynchronous active-low reset to 0). It is reused by other clock-domain blocks.

Test Plan:
All scenarios use DIV_N=5, LOCK_CNT=4, clk period 4ns, with the driver being the team's odd divider at N=5.
1. Release rstn at 6ns, enable=1 → period_vld pulses every 5 clk with period_cnt=5; locked=1 coincident with the 4th period_vld; err=0 throughout.
2. Drive clk_div_in at divide-by-7 → period_cnt=7; err=1 after the first measurement; locked stays 0.
3. After lock, hold clk_div_in=0 → 10 clk after the last counted rise, locked=0 and err=1; no period_vld; a resumed /5 clock relocks after 4 periods, with err still 1.
4. Pulse enable low for 1 clk while locked → next cycle all outputs are 0; after re-enable, locked returns only after the first-edge discard plus 4 matching periods.
5. Assert rstn low mid-period while locked → all outputs 0 without waiting for a clk edge.
6. With CLK_DIV_MON_DUTY_CHK_EN, inject a period-5 clock with high time 1 → err=1 and locked=0. Without the macro, the same stimulus keeps locked=1 and reports high_cnt=1.
